// File: rtl/mm_ctrl_pkg.sv
// Shared types and helpers for the parallel BRAM matrix-multiply sequencer.
//   ctrl_state_t  : sequencer state encoding
//   timeout_width : bits needed for a watchdog that must hold values 0..t
package mm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } ctrl_state_t;

    function automatic int unsigned timeout_width(input int unsigned t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mm_ctrl_delay_line.sv
// Resettable shift register that delays a {valid, addr} word by DEPTH cycles.
//   clk, reset (sync, active-low) : clock / flush of every stage
//   d [WIDTH]                     : word entering the line
//   q [WIDTH]                     : word leaving the line, DEPTH cycles later
module mm_ctrl_delay_line #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/mm_bram_parallel_ctrl.sv
// Sequencer for the parallel BRAM matrix-multiply datapath.
// Streams row addresses 0..last to the source SRAM, re-times the read strobe and
// address to line up with the returning row data, counts datapath writebacks and
// pulses done when all rows are back (or when the drain watchdog expires).
//   start / cfg_last_row        : job request, sampled only while idle
//   issue_hold                  : stall read issue for this cycle
//   src_rd_en / src_rdaddr      : source SRAM read port
//   dpath_sum_en / ..._wraddr   : row-valid and result address aligned to data
//   wb_val                      : datapath writeback strobe
//   busy / done / err           : status; err is sticky until the next job
module mm_bram_parallel_ctrl
    import mm_ctrl_pkg::*;
#(
    parameter int unsigned ROW_NUM        = 32,
    parameter int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM),
    parameter int unsigned SRC_RD_LAT     = 1,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROW_ADDR_WIDTH-1:0] cfg_last_row,
    input  logic                      issue_hold,
    output logic                      src_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0] src_rdaddr,
    output logic                      dpath_sum_en,
    output logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr,
    input  logic                      wb_val,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned CNT_W = ROW_ADDR_WIDTH + 1;
    localparam int unsigned WD_W  = timeout_width(TIMEOUT);

    ctrl_state_t               state;
    logic [ROW_ADDR_WIDTH-1:0] last_row;
    logic [ROW_ADDR_WIDTH-1:0] issue_cnt;
    logic [CNT_W-1:0]          wb_cnt;
    logic [CNT_W-1:0]          job_rows;
    logic [WD_W-1:0]           wd_cnt;

    // Widened so that last_row == ROW_NUM-1 still yields the full row count.
    assign job_rows = {1'b0, last_row} + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_row   <= '0;
            issue_cnt  <= '0;
            wb_cnt     <= '0;
            wd_cnt     <= '0;
            src_rd_en  <= 1'b0;
            src_rdaddr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            src_rd_en <= 1'b0;
            done      <= 1'b0;

            // Counted independently of the state transitions so a writeback
            // landing on the last issue or on DRAIN entry is never dropped.
            if (wb_val && (state == ISSUE || state == DRAIN)) begin
                wb_cnt <= wb_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        last_row  <= cfg_last_row;
                        issue_cnt <= '0;
                        wb_cnt    <= '0;
                        wd_cnt    <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    if (!issue_hold) begin
                        src_rd_en  <= 1'b1;
                        src_rdaddr <= issue_cnt;
                        issue_cnt  <= issue_cnt + ROW_ADDR_WIDTH'(1);
                        if (issue_cnt == last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wb_cnt == job_rows) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (wb_val) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mm_ctrl_delay_line #(
        .WIDTH (ROW_ADDR_WIDTH + 1),
        .DEPTH (SRC_RD_LAT)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({src_rd_en, src_rdaddr}),
        .q     ({dpath_sum_en, dpath_result_wraddr})
    );

endmodule
